sqrt_pipe_ctrl: RTL and testbench

Sequencer for the pipelined square-root datapath. It runs the 8-iteration digit-by-digit integer square root of a 16-bit radicand on the shared two-stage pipelined carry-lookahead adder. It drives the adder operands, the carry-in, the pipe enable and the valid token, and it consumes the sum and carry-out that leave the final stage. It sits between the host start/done handshake and the adder pipeline, holds the root and remainder state, and has one operation in flight at a time.

---
 rtl/sqrt_pipe_ctrl_if.sv | 50 +++++
 rtl/sqrt_pipe_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sqrt_pipe_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_ctrl_if
//
// Bundles the two buses of the square-root sequencer:
//   * host side   : start_i / radicand_i / hold_i in, busy_o / done_o / err_o /
//                   root_o / rem_o out.
//   * adder side  : en_pipe_o / issue_o / op_a_o / op_b_o / cin_o out to the
//                   shared pipelined carry-lookahead adder, res_valid_i /
//                   res_i / co_i back from its last stage.
//
// Signal names keep the controller's point of view (_i = into controller,
// _o = out of controller) so that both ends read the same way.
//   slave  : the controller (sqrt_pipe_ctrl).
//   master : the environment, i.e. the host plus the adder pipeline.
// -----------------------------------------------------------------------------
interface sqrt_pipe_ctrl_if;
    // Host handshake
    logic        start_i;
    logic [15:0] radicand_i;
    logic        hold_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  root_o;
    logic [8:0]  rem_o;

    // Adder pipeline
    logic        en_pipe_o;
    logic        issue_o;
    logic [15:0] op_a_o;
    logic [15:0] op_b_o;
    logic        cin_o;
    logic        res_valid_i;
    logic [15:0] res_i;
    logic        co_i;

    modport slave (
        input  start_i, radicand_i, hold_i,
        input  res_valid_i, res_i, co_i,
        output busy_o, done_o, err_o, root_o, rem_o,
        output en_pipe_o, issue_o, op_a_o, op_b_o, cin_o
    );

    modport master (
        output start_i, radicand_i, hold_i,
        output res_valid_i, res_i, co_i,
        input  busy_o, done_o, err_o, root_o, rem_o,
        input  en_pipe_o, issue_o, op_a_o, op_b_o, cin_o
    );
endinterface

// File: rtl/sqrt_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_ctrl
//
// Sequencer for the digit-by-digit integer square root of a 16-bit radicand.
// Each of the 8 iterations forms the trial subtraction
//     {rem, next two radicand bits} - {root, 2'b01}
// on the shared pipelined adder (A + ~B + 1), waits PIPE_LAT cycles for the
// result, and then shifts one root bit in.  One operation in flight at a time.
//
// Parameters
//   PIPE_LAT    adder latency from issue edge to res_valid_i (1..4).
//
// Ports
//   clk         rising-edge clock.
//   rst         synchronous, active-high reset.
//   bus.slave   host handshake and adder pipeline signals (sqrt_pipe_ctrl_if):
//     start_i     start request, only looked at in IDLE.
//     radicand_i  captured on the accepted start edge.
//     hold_i      global stall: freezes the controller and the adder pipe.
//     busy_o      high in every state except IDLE.
//     done_o      one-cycle pulse; root_o/rem_o are valid in that cycle.
//     err_o       one-cycle pulse; adder result did not arrive in time.
//     root_o      8-bit root, held until the next completed operation.
//     rem_o       9-bit remainder radicand - root^2, held likewise.
//     en_pipe_o   enable for every adder pipeline register (= !hold_i).
//     issue_o     valid token into adder stage 1.
//     op_a_o      adder operand A.
//     op_b_o      adder operand B, already inverted.
//     cin_o       adder carry-in, tied to 1 (subtract).
//     res_valid_i valid token out of the last adder stage.
//     res_i       adder sum.
//     co_i        adder carry-out; 1 means A >= B.
// -----------------------------------------------------------------------------
module sqrt_pipe_ctrl #(
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    sqrt_pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // to_q counts missed cycles in WAIT; seeing it at PIPE_LAT-1 with no
    // result means this cycle is the PIPE_LAT-th miss.
    localparam logic [2:0] TO_LAST = 3'(PIPE_LAT - 1);
    localparam logic [2:0] IT_LAST = 3'd7;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [15:0] rad_q,      rad_d;
    logic [8:0]  rem_q,      rem_d;
    logic [7:0]  root_q,     root_d;
    logic [2:0]  it_q,       it_d;
    logic [2:0]  to_q,       to_d;
    logic [7:0]  root_out_q, root_out_d;
    logic [8:0]  rem_out_q,  rem_out_d;
    logic        err_q,      err_d;

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    logic [10:0] rem_sh;
    logic [9:0]  trial;
    logic [7:0]  root_nx;
    logic [8:0]  rem_nx;

    assign rem_sh = {rem_q, rad_q[15:14]};
    assign trial  = {root_q, 2'b01};

    // Carry-out set means the trial fits: keep the difference, shift in a 1.
    // Otherwise the shifted remainder stands and a 0 is shifted in.  The
    // remainder never exceeds 2*root, so only the low 9 bits carry content.
    assign root_nx = {root_q[6:0], bus.co_i};
    assign rem_nx  = bus.co_i ? bus.res_i[8:0] : rem_sh[8:0];

    // Upper sum bits are zero for every subtraction the controller consumes.
    logic unused_res_hi;
    assign unused_res_hi = ^bus.res_i[15:9];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        it_d       = it_q;
        to_d       = to_q;
        root_out_d = root_out_q;
        rem_out_d  = rem_out_q;
        err_d      = 1'b0;

        // A held cycle changes nothing; the whole sequencer simply stretches.
        if (!bus.hold_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        rad_d   = bus.radicand_i;
                        rem_d   = '0;
                        root_d  = '0;
                        it_d    = '0;
                        state_d = S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    to_d    = '0;
                    state_d = S_WAIT;
                end

                S_WAIT: begin
                    if (bus.res_valid_i) begin
                        rem_d  = rem_nx;
                        root_d = root_nx;
                        rad_d  = {rad_q[13:0], 2'b00};
                        it_d   = it_q + 3'd1;
                        if (it_q == IT_LAST) begin
                            // Result registers load on the way into DONE so
                            // they are already valid while done_o is high.
                            root_out_d = root_nx;
                            rem_out_d  = rem_nx;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        to_d = to_q + 3'd1;
                        if (to_q == TO_LAST) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            it_q       <= '0;
            to_q       <= '0;
            root_out_q <= '0;
            rem_out_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            it_q       <= it_d;
            to_q       <= to_d;
            root_out_q <= root_out_d;
            rem_out_q  <= rem_out_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Operands are only meaningful in ISSUE; elsewhere they rest at 0 - 0.
    assign bus.op_a_o    = (state_q == S_ISSUE) ? {5'b0, rem_sh}   : 16'h0000;
    assign bus.op_b_o    = (state_q == S_ISSUE) ? ~{6'b0, trial}   : 16'hFFFF;
    assign bus.cin_o     = 1'b1;
    assign bus.issue_o   = (state_q == S_ISSUE) && !bus.hold_i;
    // The adder keeps running in IDLE so stale tokens drain out.
    assign bus.en_pipe_o = !bus.hold_i;
    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.done_o    = (state_q == S_DONE);
    assign bus.err_o     = err_q;
    assign bus.root_o    = root_out_q;
    assign bus.rem_o     = rem_out_q;

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Testbench for sqrt_pipe_ctrl: table-driven vectors, hand-written corner
// sequences and randomized radicands/stalls against an arithmetic model.
module tb_sqrt_pipe_ctrl;

    localparam int PL = 2;

    logic clk;
    logic rst;

    sqrt_pipe_ctrl_if bus();

    sqrt_pipe_ctrl #(.PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Adder pipeline model: PL register stages, A + B + cin at the output.
    // drop_iter selects an issue index (within one busy period) whose
    // valid token is lost.
    // ------------------------------------------------------------------
    int          drop_iter;
    int          iss_cnt;
    logic [PL-1:0] vld_pipe;
    logic [15:0] a_pipe [PL];
    logic [15:0] b_pipe [PL];
    logic        c_pipe [PL];
    logic [16:0] sum;

    always @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            iss_cnt  <= 0;
        end else begin
            if (bus.en_pipe_o) begin
                vld_pipe[0] <= bus.issue_o && (iss_cnt != drop_iter);
                a_pipe[0]   <= bus.op_a_o;
                b_pipe[0]   <= bus.op_b_o;
                c_pipe[0]   <= bus.cin_o;
                for (int i = 1; i < PL; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    a_pipe[i]   <= a_pipe[i-1];
                    b_pipe[i]   <= b_pipe[i-1];
                    c_pipe[i]   <= c_pipe[i-1];
                end
                if (bus.issue_o) iss_cnt <= iss_cnt + 1;
            end
            if (!bus.busy_o) iss_cnt <= 0;
        end
    end

    assign sum             = {1'b0, a_pipe[PL-1]} + {1'b0, b_pipe[PL-1]} + {16'b0, c_pipe[PL-1]};
    assign bus.res_valid_i = vld_pipe[PL-1];
    assign bus.res_i       = sum[15:0];
    assign bus.co_i        = sum[16];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int tests;
    int fails;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Observations gathered by run_seq
    int          d_cnt;
    int          d_cyc  [2];
    int          d_root [2];
    int          d_rem  [2];
    int          e_cnt, e_cyc, e_busy;
    int          iss_hold_bad, en_bad, hi_bad;
    logic [7:0]  co_hist;
    int          co_n;
    int          opa1, opb1;
    int          rs_busy, rs_done, rs_err, rs_issue, rs_root, rs_rem, rs_opa, rs_opb, rs_cin;

    // Starts an operation in the current cycle (cycle 0, DUT in IDLE) and
    // observes it for at most max_cyc cycles.  Returns with the DUT idle,
    // one cycle after the last expected done_o, inputs quiet.
    task automatic run_seq(input logic [15:0] r0, input logic [15:0] r1, input int n_ops,
                           input int hold_from, input int hold_len, input int rst_at,
                           input int drop, input int max_cyc);
        d_cnt = 0; e_cnt = 0; e_cyc = -1; e_busy = -1;
        d_cyc[0] = -1; d_cyc[1] = -1;
        iss_hold_bad = 0; en_bad = 0; hi_bad = 0;
        co_hist = '0; co_n = 0; opa1 = -1; opb1 = -1;
        drop_iter = drop;
        bus.radicand_i = r0;
        bus.start_i    = 1'b1;
        bus.hold_i     = (hold_len > 0) && (hold_from == 0);
        rst            = (rst_at == 0);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.en_pipe_o !== !bus.hold_i) en_bad = 1;
            if (bus.issue_o && bus.hold_i) iss_hold_bad = 1;
            if (c == 1) begin
                opa1 = int'(bus.op_a_o);
                opb1 = int'(bus.op_b_o);
            end
            if (bus.res_valid_i && !bus.hold_i && bus.busy_o && !bus.done_o) begin
                co_hist = {co_hist[6:0], bus.co_i};
                co_n++;
                if (bus.co_i && bus.res_i[15:9] != 7'd0) hi_bad = 1;
            end
            if (bus.done_o && d_cnt < 2) begin
                d_cyc[d_cnt]  = c;
                d_root[d_cnt] = int'(bus.root_o);
                d_rem[d_cnt]  = int'(bus.rem_o);
                d_cnt++;
            end
            if (bus.err_o) begin
                e_cnt++;
                e_cyc  = c;
                e_busy = int'(bus.busy_o);
            end
            if (c == rst_at + 1) begin
                rs_busy = bus.busy_o;  rs_done = bus.done_o; rs_err = bus.err_o;
                rs_issue = bus.issue_o; rs_root = bus.root_o; rs_rem = bus.rem_o;
                rs_opa = bus.op_a_o;   rs_opb = bus.op_b_o;  rs_cin = bus.cin_o;
            end
            @(posedge clk);
            #1;
            bus.start_i = (n_ops == 2) && (d_cnt < 2);
            if (d_cnt >= 1) bus.radicand_i = r1;
            bus.hold_i = (c + 1 >= hold_from) && (c + 1 < hold_from + hold_len);
            rst        = (c + 1 == rst_at);
            if (d_cnt >= n_ops) break;
        end
        bus.start_i = 1'b0;
        bus.hold_i  = 1'b0;
        rst         = 1'b0;
        drop_iter   = -1;
    endtask

    typedef struct {
        logic [15:0] rad;
        int          root;
        int          rem;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        drop_iter = -1;

        tbl[0] = '{16'd0,     0,   0};
        tbl[1] = '{16'd65535, 255, 510};
        tbl[2] = '{16'd144,   12,  0};
        tbl[3] = '{16'd50000, 223, 271};
        tbl[4] = '{16'd1,     1,   0};
        tbl[5] = '{16'd2,     1,   1};
        tbl[6] = '{16'd65024, 254, 508};
        tbl[7] = '{16'd24,    4,   8};

        // ---------------- reset state ----------------
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.radicand_i = 16'h0;
        bus.hold_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  bus.busy_o,  0);
        chk("rst_done",  bus.done_o,  0);
        chk("rst_err",   bus.err_o,   0);
        chk("rst_issue", bus.issue_o, 0);
        chk("rst_root",  bus.root_o,  0);
        chk("rst_rem",   bus.rem_o,   0);
        chk("rst_opa",   bus.op_a_o,  0);
        chk("rst_opb",   bus.op_b_o,  16'hFFFF);
        chk("rst_cin",   bus.cin_o,   1);
        chk("rst_en",    bus.en_pipe_o, 1);
        bus.hold_i = 1'b1;
        #1;
        chk("rst_en_hold", bus.en_pipe_o, 0);
        @(posedge clk);
        #1;
        bus.hold_i = 1'b0;
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 8; i++) begin
            run_seq(tbl[i].rad, 16'h0, 1, 0, 0, -1, -1, 40);
            chk($sformatf("tbl%0d_done_cyc", i), d_cyc[0], 25);
            chk($sformatf("tbl%0d_root", i), d_root[0], tbl[i].root);
            chk($sformatf("tbl%0d_rem", i), d_rem[0], tbl[i].rem);
            chk($sformatf("tbl%0d_opa1", i), opa1, int'(tbl[i].rad >> 14));
            chk($sformatf("tbl%0d_opb1", i), opb1, 16'hFFFE);
            chk($sformatf("tbl%0d_co_n", i), co_n, 8);
            chk($sformatf("tbl%0d_res_hi", i), hi_bad, 0);
            if (tbl[i].rad == 16'd65535) chk("co_seq_65535", co_hist, 8'hFF);
        end

        // ---------------- back-to-back with start held ----------------
        run_seq(16'd144, 16'd50000, 2, 0, 0, -1, -1, 70);
        chk("b2b_done0", d_cyc[0], 25);
        chk("b2b_root0", d_root[0], 12);
        chk("b2b_rem0",  d_rem[0], 0);
        chk("b2b_gap",   d_cyc[1] - d_cyc[0], 26);
        chk("b2b_root1", d_root[1], 223);
        chk("b2b_rem1",  d_rem[1], 271);

        // ---------------- dropped token -> timeout ----------------
        run_seq(16'd50000, 16'h0, 1, 0, 0, -1, 3, 30);
        chk("to_err_cnt",  e_cnt, 1);
        chk("to_err_cyc",  e_cyc, 13);
        chk("to_err_busy", e_busy, 0);
        chk("to_no_done",  d_cnt, 0);
        chk("to_root_kept", bus.root_o, 223);
        chk("to_rem_kept",  bus.rem_o, 271);

        // ---------------- hold during WAIT ----------------
        run_seq(16'd50000, 16'h0, 1, 2, 5, -1, -1, 45);
        chk("hold_done_cyc", d_cyc[0], 30);
        chk("hold_root", d_root[0], 223);
        chk("hold_rem",  d_rem[0], 271);
        chk("hold_issue", iss_hold_bad, 0);
        chk("hold_en",    en_bad, 0);

        // ---------------- reset mid-run ----------------
        run_seq(16'd40000, 16'h0, 1, 0, 0, 10, -1, 20);
        chk("mid_rst_busy",  rs_busy, 0);
        chk("mid_rst_done",  rs_done, 0);
        chk("mid_rst_err",   rs_err, 0);
        chk("mid_rst_issue", rs_issue, 0);
        chk("mid_rst_root",  rs_root, 0);
        chk("mid_rst_rem",   rs_rem, 0);
        chk("mid_rst_opa",   rs_opa, 0);
        chk("mid_rst_opb",   rs_opb, 16'hFFFF);
        chk("mid_rst_cin",   rs_cin, 1);
        chk("mid_rst_no_done", d_cnt, 0);
        run_seq(16'd9, 16'h0, 1, 0, 0, -1, -1, 40);
        chk("post_rst_done", d_cyc[0], 25);
        chk("post_rst_root", d_root[0], 3);
        chk("post_rst_rem",  d_rem[0], 0);

        // ---------------- randomized radicands and stalls ----------------
        for (int n = 0; n < 30; n++) begin
            logic [15:0] r;
            int hl, hf, er;
            r  = 16'($urandom_range(0, 65535));
            hl = int'($urandom_range(0, 4));
            hf = int'($urandom_range(1, 24));
            er = isqrt(int'(r));
            run_seq(r, 16'h0, 1, hf, hl, -1, -1, 45);
            chk($sformatf("rnd%0d_done_cyc(r=%0d)", n, r), d_cyc[0], 25 + hl);
            chk($sformatf("rnd%0d_root(r=%0d)", n, r), d_root[0], er);
            chk($sformatf("rnd%0d_rem(r=%0d)", n, r), d_rem[0], int'(r) - er * er);
            chk($sformatf("rnd%0d_issue_hold", n), iss_hold_bad, 0);
            chk($sformatf("rnd%0d_en_pipe", n), en_bad, 0);
            chk($sformatf("rnd%0d_res_hi", n), hi_bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
